// File: rtl/tft_vid_monitor.sv
// Pixel-clock sink monitor for the clocked-video TFT stream: measures frame
// geometry, sums active pixels per frame, tracks lock and counts underflows.
module tft_vid_monitor #(
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 12,
    parameter int H_ACTIVE    = 800,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic [DATA_W-1:0] vid_data,
    input  logic              vid_datavalid,
    input  logic              vid_h_sync,
    input  logic              vid_v_sync,
    input  logic              vid_underflow,
    output logic [CNT_W-1:0]  meas_width,
    output logic [CNT_W-1:0]  meas_height,
    output logic [31:0]       frame_sum,
    output logic              meas_valid,
    output logic              err_width,
    output logic              err_height,
    output logic              locked,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       underflow_cnt
);

    localparam logic [CNT_W-1:0] H_EXP = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_EXP = CNT_W'(V_ACTIVE);
    localparam int               GR_W  = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [GR_W-1:0]  RUN_FULL = GR_W'(LOCK_FRAMES);

    typedef enum logic [0:0] {SEEK = 1'b0, FRAME = 1'b1} state_t;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1'b1);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hffff) ? v : v + 16'd1;
    endfunction

    logic              datavalid_r, datavalid_rr, vsync_r, vsync_rr, underflow_r, underflow_rr, hsync_r;
    logic [31:0]       data_r, pix_data_r;
    logic              pix_en_r, line_end_r, frame_end_r;
    logic              uf_rise_s, unused_s;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  pix_cnt_r, pix_cnt_s, line_cnt_r, line_cnt_s, last_w_r, last_w_s;
    logic [31:0]       acc_r, acc_s;
    logic              line_bad_r, line_bad_s;
    logic              err_width_r, err_width_s, err_height_r, err_height_s;
    logic [GR_W-1:0]   good_run_r, good_run_s, run_next_s;
    logic              locked_r, locked_s, meas_valid_r, meas_valid_s;
    logic [15:0]       frame_cnt_r, frame_cnt_s, underflow_cnt_r, underflow_cnt_s;
    logic [CNT_W-1:0]  meas_width_r, meas_width_s, meas_height_r, meas_height_s;
    logic [31:0]       frame_sum_r, frame_sum_s;
    logic [CNT_W-1:0]  pix_now_s, lines_now_s, last_w_now_s;
    logic [31:0]       acc_now_s;
    logic              bad_now_s, frame_good_s;

    assign uf_rise_s = underflow_r & ~underflow_rr;
    // hsync is sampled for completeness but never qualifies counting
    assign unused_s  = hsync_r;

    // Input register, second copy for edge detection, and registered events
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            datavalid_r  <= 1'b0;  datavalid_rr <= 1'b0;
            vsync_r      <= 1'b0;  vsync_rr     <= 1'b0;
            underflow_r  <= 1'b0;  underflow_rr <= 1'b0;
            hsync_r      <= 1'b0;  data_r       <= 32'd0;
            pix_en_r     <= 1'b0;  pix_data_r   <= 32'd0;
            line_end_r   <= 1'b0;  frame_end_r  <= 1'b0;
        end else begin
            datavalid_r  <= vid_datavalid;  datavalid_rr <= datavalid_r;
            vsync_r      <= vid_v_sync;     vsync_rr     <= vsync_r;
            underflow_r  <= vid_underflow;  underflow_rr <= underflow_r;
            hsync_r      <= vid_h_sync;     data_r       <= vid_data[31:0];
            pix_en_r     <= datavalid_r;    pix_data_r   <= data_r;
            line_end_r   <= datavalid_rr & ~datavalid_r;
            frame_end_r  <= vsync_r & ~vsync_rr;
        end
    end

    // Next-state, counting and frame-report logic
    always_comb begin
        state_s       = state_r;       pix_cnt_s     = pix_cnt_r;
        line_cnt_s    = line_cnt_r;    acc_s         = acc_r;
        last_w_s      = last_w_r;      line_bad_s    = line_bad_r;
        err_width_s   = err_width_r;   err_height_s  = err_height_r;
        good_run_s    = good_run_r;    locked_s      = locked_r;
        frame_cnt_s   = frame_cnt_r;   meas_valid_s  = 1'b0;
        meas_width_s  = meas_width_r;  meas_height_s = meas_height_r;
        frame_sum_s   = frame_sum_r;   run_next_s    = good_run_r;
        pix_now_s     = pix_cnt_r;     acc_now_s     = acc_r;
        lines_now_s   = line_cnt_r;    last_w_now_s  = last_w_r;
        bad_now_s     = line_bad_r;    frame_good_s  = 1'b0;
        underflow_cnt_s = uf_rise_s ? sat_inc16(underflow_cnt_r) : underflow_cnt_r;
        case (state_r)
            SEEK: begin
                if (frame_end_r) begin
                    state_s    = FRAME;
                    pix_cnt_s  = {CNT_W{1'b0}};  line_cnt_s = {CNT_W{1'b0}};
                    last_w_s   = {CNT_W{1'b0}};  acc_s      = 32'd0;
                    line_bad_s = 1'b0;
                end else begin
                    state_s = SEEK;
                end
            end
            FRAME: begin
                if (pix_en_r) begin
                    pix_now_s = sat_inc_cnt(pix_cnt_r);
                    acc_now_s = acc_r + pix_data_r;
                end else begin
                    pix_now_s = pix_cnt_r;
                    acc_now_s = acc_r;
                end
                // A line closing together with vsync belongs to the closing frame
                if (line_end_r) begin
                    last_w_now_s = pix_now_s;
                    lines_now_s  = sat_inc_cnt(line_cnt_r);
                    if (pix_now_s != H_EXP) begin
                        bad_now_s   = 1'b1;
                        err_width_s = 1'b1;
                    end else begin
                        bad_now_s = line_bad_r;
                    end
                    pix_now_s = {CNT_W{1'b0}};
                end else begin
                    last_w_now_s = last_w_r;
                    lines_now_s  = line_cnt_r;
                end
                if (frame_end_r) begin
                    meas_width_s  = last_w_now_s;
                    meas_height_s = lines_now_s;
                    frame_sum_s   = acc_now_s;
                    meas_valid_s  = 1'b1;
                    frame_cnt_s   = sat_inc16(frame_cnt_r);
                    frame_good_s  = ~bad_now_s & (lines_now_s == V_EXP);
                    if (lines_now_s != V_EXP) begin
                        err_height_s = 1'b1;
                    end else begin
                        err_height_s = err_height_r;
                    end
                    if (frame_good_s) begin
                        run_next_s = (good_run_r >= RUN_FULL) ? RUN_FULL : good_run_r + GR_W'(1'b1);
                    end else begin
                        run_next_s = {GR_W{1'b0}};
                    end
                    good_run_s = run_next_s;
                    locked_s   = (run_next_s == RUN_FULL);
                    pix_cnt_s  = {CNT_W{1'b0}};  line_cnt_s = {CNT_W{1'b0}};
                    last_w_s   = {CNT_W{1'b0}};  acc_s      = 32'd0;
                    line_bad_s = 1'b0;
                end else begin
                    pix_cnt_s  = pix_now_s;     line_cnt_s = lines_now_s;
                    last_w_s   = last_w_now_s;  acc_s      = acc_now_s;
                    line_bad_s = bad_now_s;
                end
            end
            default: state_s = SEEK;
        endcase
    end

    // State and output registers; clear keeps the last frame's measurements
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            state_r         <= SEEK;
            pix_cnt_r       <= {CNT_W{1'b0}};  line_cnt_r <= {CNT_W{1'b0}};
            last_w_r        <= {CNT_W{1'b0}};  acc_r      <= 32'd0;
            line_bad_r      <= 1'b0;           good_run_r <= {GR_W{1'b0}};
            err_width_r     <= 1'b0;           err_height_r <= 1'b0;
            locked_r        <= 1'b0;           meas_valid_r <= 1'b0;
            frame_cnt_r     <= 16'd0;          underflow_cnt_r <= 16'd0;
            if (!reset_n) begin
                meas_width_r  <= {CNT_W{1'b0}};
                meas_height_r <= {CNT_W{1'b0}};
                frame_sum_r   <= 32'd0;
            end
        end else begin
            state_r         <= state_s;
            pix_cnt_r       <= pix_cnt_s;      line_cnt_r <= line_cnt_s;
            last_w_r        <= last_w_s;       acc_r      <= acc_s;
            line_bad_r      <= line_bad_s;     good_run_r <= good_run_s;
            err_width_r     <= err_width_s;    err_height_r <= err_height_s;
            locked_r        <= locked_s;       meas_valid_r <= meas_valid_s;
            frame_cnt_r     <= frame_cnt_s;    underflow_cnt_r <= underflow_cnt_s;
            meas_width_r    <= meas_width_s;   meas_height_r <= meas_height_s;
            frame_sum_r     <= frame_sum_s;
        end
    end

    assign meas_width    = meas_width_r;
    assign meas_height   = meas_height_r;
    assign frame_sum     = frame_sum_r;
    assign meas_valid    = meas_valid_r;
    assign err_width     = err_width_r;
    assign err_height    = err_height_r;
    assign locked        = locked_r;
    assign frame_cnt     = frame_cnt_r;
    assign underflow_cnt = underflow_cnt_r;

endmodule

// File: tb/tb_tft_vid_monitor.sv
// Bench for tft_vid_monitor: directed frame table plus randomized frames checked
// against a frame-level model (line lengths, pixel sums, good-frame run).
module tb_tft_vid_monitor;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int LF = 2;

    logic        clk = 1'b0;
    logic        reset_n, clear;
    logic [31:0] vid_data;
    logic        vid_datavalid, vid_h_sync, vid_v_sync, vid_underflow;
    logic [11:0] meas_width, meas_height;
    logic [31:0] frame_sum;
    logic        meas_valid, err_width, err_height, locked;
    logic [15:0] frame_cnt, underflow_cnt;

    tft_vid_monitor #(.DATA_W(32), .CNT_W(12), .H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(LF)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .vid_data(vid_data),
        .vid_datavalid(vid_datavalid), .vid_h_sync(vid_h_sync), .vid_v_sync(vid_v_sync),
        .vid_underflow(vid_underflow), .meas_width(meas_width), .meas_height(meas_height),
        .frame_sum(frame_sum), .meas_valid(meas_valid), .err_width(err_width),
        .err_height(err_height), .locked(locked), .frame_cnt(frame_cnt),
        .underflow_cnt(underflow_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame-level reference model
    bit          m_in_frame, m_errw, m_errh, fr_bad;
    int          m_run, m_fcnt, fr_lines, fr_last, pix_idx;
    logic [31:0] fr_sum, m_last_w, m_last_h, m_last_sum;
    logic [31:0] cap_w, cap_h, cap_sum, cap_fcnt;
    logic        cap_errw, cap_errh, cap_locked;

    typedef struct {
        int          nlines;
        int          short_idx;
        int          short_len;
        bit          coinc;
        bit          exp_rep;
        int          exp_w;
        int          exp_h;
        logic [31:0] exp_sum;
        bit          exp_errw;
        bit          exp_errh;
        bit          exp_locked;
        int          exp_fcnt;
    } vec_t;
    vec_t vt[10];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_in_frame = 1'b0; m_errw = 1'b0; m_errh = 1'b0; m_run = 0; m_fcnt = 0;
        fr_lines = 0; fr_last = 0; fr_bad = 1'b0; fr_sum = 32'd0; pix_idx = 0;
    endtask

    task automatic send_line(input int len, input bit rnd, input int gap);
        for (int i = 0; i < len; i++) begin
            vid_datavalid = 1'b1;
            vid_data = rnd ? $urandom : 32'(pix_idx);
            if (m_in_frame) fr_sum = fr_sum + vid_data;
            pix_idx++;
            tick();
        end
        vid_datavalid = 1'b0;
        if (m_in_frame) begin
            fr_lines++;
            fr_last = len;
            if (len != H) begin fr_bad = 1'b1; m_errw = 1'b1; end
        end
        for (int g = 0; g < gap; g++) begin
            vid_h_sync = (g == 0);
            tick();
        end
        vid_h_sync = 1'b0;
    endtask

    task automatic send_vsync(input string tag);
        int pulses;
        int lat;
        bit good;
        pulses = 0; lat = -1;
        vid_v_sync = 1'b1; vid_datavalid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (meas_valid === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    cap_w = 32'(meas_width); cap_h = 32'(meas_height); cap_sum = frame_sum;
                    cap_errw = err_width; cap_errh = err_height; cap_locked = locked;
                    cap_fcnt = 32'(frame_cnt);
                end
            end
            if (k == 2) vid_v_sync = 1'b0;
        end
        if (m_in_frame) begin
            good = !fr_bad && (fr_lines == V);
            if (fr_lines != V) m_errh = 1'b1;
            m_run = good ? ((m_run < LF) ? m_run + 1 : LF) : 0;
            m_fcnt = (m_fcnt < 65535) ? m_fcnt + 1 : 65535;
            check({tag, " pulses"},  32'(pulses), 32'd1);
            check({tag, " latency"}, 32'(lat), 32'd3);
            check({tag, " width"},   cap_w, 32'(fr_last));
            check({tag, " height"},  cap_h, 32'(fr_lines));
            check({tag, " sum"},     cap_sum, fr_sum);
            check({tag, " errw"},    32'(cap_errw), 32'(m_errw));
            check({tag, " errh"},    32'(cap_errh), 32'(m_errh));
            check({tag, " locked"},  32'(cap_locked), 32'(m_run == LF));
            check({tag, " fcnt"},    cap_fcnt, 32'(m_fcnt));
            m_last_w = 32'(fr_last); m_last_h = 32'(fr_lines); m_last_sum = fr_sum;
        end else begin
            check({tag, " no report"}, 32'(pulses), 32'd0);
        end
        m_in_frame = 1'b1;
        fr_lines = 0; fr_last = 0; fr_bad = 1'b0; fr_sum = 32'd0; pix_idx = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " width"},  32'(meas_width), 32'd0);
        check({tag, " height"}, 32'(meas_height), 32'd0);
        check({tag, " sum"},    frame_sum, 32'd0);
        check({tag, " valid"},  32'(meas_valid), 32'd0);
        check({tag, " errw"},   32'(err_width), 32'd0);
        check({tag, " errh"},   32'(err_height), 32'd0);
        check({tag, " locked"}, 32'(locked), 32'd0);
        check({tag, " fcnt"},   32'(frame_cnt), 32'd0);
        check({tag, " ufcnt"},  32'(underflow_cnt), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, nl, r;
        // nlines, short_idx, short_len, coinc, rep, w, h, sum, errw, errh, locked, fcnt
        vt[0] = '{4, -1, 0, 1'b0, 1'b0, 0, 0, 32'd0,   1'b0, 1'b0, 1'b0, 0};
        vt[1] = '{4, -1, 0, 1'b0, 1'b1, 8, 4, 32'd496, 1'b0, 1'b0, 1'b0, 1};
        vt[2] = '{4, -1, 0, 1'b0, 1'b1, 8, 4, 32'd496, 1'b0, 1'b0, 1'b1, 2};
        vt[3] = '{4,  2, 7, 1'b0, 1'b1, 8, 4, 32'd465, 1'b1, 1'b0, 1'b0, 3};
        vt[4] = '{4, -1, 0, 1'b0, 1'b1, 8, 4, 32'd496, 1'b1, 1'b0, 1'b0, 4};
        vt[5] = '{4, -1, 0, 1'b0, 1'b1, 8, 4, 32'd496, 1'b1, 1'b0, 1'b1, 5};
        vt[6] = '{5, -1, 0, 1'b0, 1'b1, 8, 5, 32'd780, 1'b1, 1'b1, 1'b0, 6};
        vt[7] = '{0, -1, 0, 1'b0, 1'b1, 0, 0, 32'd0,   1'b1, 1'b1, 1'b0, 7};
        vt[8] = '{4, -1, 0, 1'b1, 1'b1, 8, 4, 32'd496, 1'b1, 1'b1, 1'b0, 8};
        vt[9] = '{4, -1, 0, 1'b1, 1'b1, 8, 4, 32'd496, 1'b1, 1'b1, 1'b1, 9};

        reset_n = 1'b0; clear = 1'b0; vid_data = 32'd0; vid_datavalid = 1'b0;
        vid_h_sync = 1'b0; vid_v_sync = 1'b0; vid_underflow = 1'b0;
        model_clear();
        m_last_w = 32'd0; m_last_h = 32'd0; m_last_sum = 32'd0;
        repeat (4) tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) tick();

        // Directed frame table
        for (int i = 0; i < 10; i++) begin
            for (int l = 0; l < vt[i].nlines; l++) begin
                len = (l == vt[i].short_idx) ? vt[i].short_len : H;
                send_line(len, 1'b0, (vt[i].coinc && l == vt[i].nlines - 1) ? 0 : 3);
            end
            send_vsync($sformatf("vec%0d", i));
            if (vt[i].exp_rep) begin
                check($sformatf("vec%0d tbl width", i),  cap_w, 32'(vt[i].exp_w));
                check($sformatf("vec%0d tbl height", i), cap_h, 32'(vt[i].exp_h));
                check($sformatf("vec%0d tbl sum", i),    cap_sum, vt[i].exp_sum);
                check($sformatf("vec%0d tbl errw", i),   32'(cap_errw), 32'(vt[i].exp_errw));
                check($sformatf("vec%0d tbl errh", i),   32'(cap_errh), 32'(vt[i].exp_errh));
            end
            check($sformatf("vec%0d tbl locked", i), 32'(locked), 32'(vt[i].exp_locked));
            check($sformatf("vec%0d tbl fcnt", i),   32'(frame_cnt), 32'(vt[i].exp_fcnt));
        end

        // Randomized frames against the model
        clear = 1'b1; tick(); clear = 1'b0; tick();
        model_clear();
        send_vsync("rnd start");
        for (int f = 0; f < 15; f++) begin
            r  = $urandom_range(0, 7);
            nl = (r == 0) ? V - 1 : ((r == 1) ? V + 1 : V);
            for (int l = 0; l < nl; l++) begin
                r = $urandom_range(0, 9);
                len = (r == 0) ? H - 1 : ((r == 1) ? H + 1 : H);
                send_line(len, 1'b1, (l == nl - 1 && $urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 4));
            end
            send_vsync($sformatf("rnd%0d", f));
        end

        // Clear mid-frame
        send_line(7, 1'b1, 4);
        send_line(H, 1'b1, 4);
        check("pre-clear errw", 32'(err_width), 32'd1);
        clear = 1'b1; tick(); clear = 1'b0; tick();
        model_clear();
        check("clear errw",   32'(err_width), 32'd0);
        check("clear errh",   32'(err_height), 32'd0);
        check("clear locked", 32'(locked), 32'd0);
        check("clear fcnt",   32'(frame_cnt), 32'd0);
        check("clear width",  32'(meas_width), m_last_w);
        check("clear height", 32'(meas_height), m_last_h);
        check("clear sum",    frame_sum, m_last_sum);
        send_line(H, 1'b1, 3);
        send_line(H, 1'b1, 3);
        send_vsync("after clear");
        for (int l = 0; l < V; l++) send_line(H, 1'b1, 3);
        send_vsync("first after clear");

        // Underflow edges and saturation
        for (int p = 0; p < 5; p++) begin
            vid_underflow = 1'b1; tick(); vid_underflow = 1'b0; tick(); tick();
        end
        vid_underflow = 1'b1; repeat (10) tick(); vid_underflow = 1'b0; repeat (4) tick();
        check("uf count", 32'(underflow_cnt), 32'd6);
        force dut.underflow_cnt_r = 16'hffff;
        tick();
        release dut.underflow_cnt_r;
        tick();
        vid_underflow = 1'b1; tick(); vid_underflow = 1'b0; repeat (4) tick();
        check("uf saturate", 32'(underflow_cnt), 32'h0000ffff);

        // Reset mid-frame
        send_line(H, 1'b1, 3);
        send_line(7, 1'b1, 4);
        check("pre-reset errw", 32'(err_width), 32'd1);
        for (int i = 0; i < 3; i++) begin
            vid_datavalid = 1'b1; vid_data = $urandom; tick();
        end
        reset_n = 1'b0; tick(); tick();
        check_all_zero("midreset");
        reset_n = 1'b1; vid_datavalid = 1'b0; tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tft_vid_monitor.md
Name: tft_vid_monitor

Overview:
- Sink-side companion to the soc_system clocked-video TFT output.
- Samples the vid_data / vid_datavalid / vid_h_sync / vid_v_sync / vid_underflow stream in the pixel clock domain.
- Measures the active width and height of each frame, checks them against the expected panel geometry, and accumulates a per-frame pixel checksum.
- Counts underflow events and frames, and reports lock status for board bring-up and for the HPS through a PIO.

Parameters:
- DATA_W, 32, pixel bus width.
- CNT_W, 12, width of the pixel and line counters.
- H_ACTIVE, 800, expected active pixels per line.
- V_ACTIVE, 480, expected active lines per frame.
- LOCK_FRAMES, 2, number of consecutive good frames required to assert locked.

Ports:
- clk, in, 1, pixel clock (same clock as video_tft_vid_clk).
- reset_n, in, 1, synchronous active-low reset.
- clear, in, 1, synchronous clear of counters, sticky errors and lock.
- vid_data, in, DATA_W, pixel data.
- vid_datavalid, in, 1, active pixel qualifier.
- vid_h_sync, in, 1, hsync, active high (monitored only).
- vid_v_sync, in, 1, vsync, active high.
- vid_underflow, in, 1, underflow flag from the source.
- meas_width, out, CNT_W, pixel count of the last line of the last completed frame.
- meas_height, out, CNT_W, line count of the last completed frame.
- frame_sum, out, 32, modulo-2^32 sum of the low 32 bits of all active pixels in the last frame.
- meas_valid, out, 1, one-cycle pulse when the meas_* outputs and frame_sum update.
- err_width, out, 1, sticky: some line in a counted frame had pixel count != H_ACTIVE.
- err_height, out, 1, sticky: a completed frame had line count != V_ACTIVE.
- locked, out, 1, geometry stable.
- frame_cnt, out, 16, completed frames, saturating.
- underflow_cnt, out, 16, vid_underflow rising edges, saturating.

Behaviour:
- Register stage: every input is registered once (the r_* stage). Edge detection compares the r_* stage against a second registered copy.
- Reset (reset_n low at a clk edge):
  - All outputs go to 0.
  - The FSM enters SEEK.
  - Internal counters are zeroed.
- clear: the same effect as reset, except that meas_width, meas_height and frame_sum are kept. clear has priority over every event in the same cycle.
- FSM states:
  - SEEK: ignore pixels. On a vsync rising edge, go to FRAME with pix_cnt=0, line_cnt=0, acc=0. No frame is reported.
  - FRAME: count pixels and lines.
    - On a vsync rising edge: close the frame, report it, reset the counters and stay in FRAME.
    - A partial first frame is never reported, because SEEK discards it.
- Pixel and line counting, in FRAME:
  - Each cycle with r_datavalid=1: pix_cnt += 1 (saturates at 2^CNT_W-1) and acc += r_vid_data[31:0].
  - Datavalid falling edge closes a line:
    - last_w <= pix_cnt (including the current cycle's increment, if any).
    - line_cnt += 1 (saturating).
    - If pix_cnt != H_ACTIVE, set err_width.
    - pix_cnt <= 0.
- Frame close (vsync rising edge in FRAME):
  - If a line close falls in the same cycle, the line is closed first and included in the frame.
  - The next clk edge updates:
    - meas_width <= last_w.
    - meas_height <= line_cnt.
    - frame_sum <= acc.
    - meas_valid <= 1 for exactly one cycle.
    - frame_cnt += 1 (saturating at 0xFFFF).
  - If line_cnt != V_ACTIVE, set err_height.
  - A zero-line frame reports height 0 and width 0, and sets err_height.
- Latency: meas_valid is high in the 3rd clk cycle after the first cycle vid_v_sync is sampled high (input register, edge detect, output register).
- locked:
  - A frame is good when every line matched H_ACTIVE and line_cnt == V_ACTIVE.
  - good_run counts consecutive good frames and saturates at LOCK_FRAMES.
  - locked=1 when good_run == LOCK_FRAMES. It updates in the same cycle as meas_valid.
  - A bad frame clears good_run and locked on that same edge.
- underflow_cnt: +1 on each vid_underflow rising edge, in any state. Saturates at 0xFFFF.
- vid_h_sync does not affect counting; lines are delimited by datavalid only.
- Datavalid high while vsync is high is still counted (frame close happens only on the vsync edge).

Test Plan:
- Nominal (H_ACTIVE=8, V_ACTIVE=4): after reset, send 3 frames of 4 lines × 8 pixels, data = pixel index 0..31.
  - Expected: no report for frame 0 (SEEK); then meas_valid pulses with width=8, height=4, frame_sum=496.
  - Expected: locked=1 after the 2nd reported frame; err_width=0, err_height=0; frame_cnt=2.
- Short line: one line of 7 pixels inside a locked stream.
  - Expected: err_width=1 (sticky), and locked=0 at that frame's meas_valid.
  - Expected: locked returns to 1 only after 2 further good frames.
- Height error and zero-line frame: a frame of 5 lines, then two vsyncs with no datavalid between them.
  - Expected: first report height=5, err_height=1; second report height=0, width=0.
- Coincident events: the last datavalid falling edge lands in the same sampled cycle as the vsync rising edge.
  - Expected: height=4 (that line is included), and meas_valid exactly 3 cycles after vsync is first driven high.
- Underflow and saturation: 5 underflow pulses, plus one level held for 10 cycles.
  - Expected: underflow_cnt=6.
  - Force underflow_cnt to 0xFFFF; one more pulse leaves it at 0xFFFF.
- Clear and reset mid-frame:
  - clear mid-frame: errors, counters and locked go to 0, meas_* keep their values, the FSM goes to SEEK, and the next full frame is not reported.
  - reset_n low mid-frame: all outputs go to 0.
